// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin arbiter giving the I (fetch) and D (load/store) ports access to one multi-cycle RAM.
// Latency : grant on the IDLE edge, RAM status sampled 10 edges later, ack high for one cycle; 12 cycles per access.
// Backpress: requesters hold req until their ack; a losing or late request waits in place, with no queueing.
//
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   i_req/i_addr             fetch request and byte address; held until i_ack
//   i_ack/i_rdata            fetch completion pulse and data (held until the next fetch completes)
//   d_req/d_we/d_addr/d_wdata  load/store request; held until d_ack
//   d_ack/d_rdata            load/store completion pulse and load data
//   mem_addr/mem_wdata       RAM address and write data, stable for the whole access
//   mem_nRD/mem_nWR          RAM strobes, active-low, never both low
//   mem_rdata                RAM read data, valid while mem_readStatus is high
//   mem_readStatus/mem_writeStatus  RAM completion pulses
//   busy                     high in every state except IDLE
//   err                      sticky watchdog flag, cleared only by reset
//
// TIMEOUT and QUIET must both fit the CW-bit counter (2**CW > max(TIMEOUT, QUIET)).

module mem_port_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int QUIET   = 12,
   parameter int CW      = 5
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,

   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_nRD,
   output logic        mem_nWR,
   input  logic [31:0] mem_rdata,
   input  logic        mem_readStatus,
   input  logic        mem_writeStatus,

   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      S_QUIET   = 3'd0,
      S_IDLE    = 3'd1,
      S_RD      = 3'd2,
      S_WR      = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [CW-1:0] QUIET_LAST   = CW'(QUIET - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   state_t        state_q,     state_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          prio_d_q,    prio_d_d;     // 1: D wins the next tie
   logic          owner_d_q,   owner_d_d;    // 1: current access belongs to D
   logic [31:0]   mem_addr_q,  mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          mem_nrd_q,   mem_nrd_d;
   logic          mem_nwr_q,   mem_nwr_d;
   logic          i_ack_q,     i_ack_d;
   logic          d_ack_q,     d_ack_d;
   logic [31:0]   i_rdata_q,   i_rdata_d;
   logic [31:0]   d_rdata_q,   d_rdata_d;
   logic          busy_q,      busy_d;
   logic          err_q,       err_d;

   logic          grant_d;
   logic          grant_i;
   logic          status;

   // D takes the slot when it is the only requester or holds the tie priority.
   assign grant_d = d_req & (~i_req | prio_d_q);
   assign grant_i = i_req & ~grant_d;

   // Only the status pulse that belongs to the strobe we are driving counts.
   assign status = (state_q == S_RD) ? mem_readStatus : mem_writeStatus;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prio_d_d    = prio_d_q;
      owner_d_d   = owner_d_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_nrd_d   = mem_nrd_q;
      mem_nwr_d   = mem_nwr_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;

      case (state_q)
         S_QUIET: begin
            // The RAM has no reset; let anything it started before reset drain.
            mem_nrd_d = 1'b1;
            mem_nwr_d = 1'b1;
            if (cnt_q == QUIET_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_IDLE: begin
            cnt_d = '0;
            if (grant_d) begin
               owner_d_d  = 1'b1;
               prio_d_d   = 1'b0;
               mem_addr_d = d_addr;
               if (d_we) begin
                  mem_wdata_d = d_wdata;
                  mem_nwr_d   = 1'b0;
                  state_d     = S_WR;
               end else begin
                  mem_nrd_d = 1'b0;
                  state_d   = S_RD;
               end
            end else if (grant_i) begin
               owner_d_d  = 1'b0;
               prio_d_d   = 1'b1;
               mem_addr_d = i_addr;
               mem_nrd_d  = 1'b0;
               state_d    = S_RD;
            end
         end

         S_RD, S_WR: begin
            // Status wins over the watchdog when both land on the same edge.
            if (status) begin
               mem_nrd_d = 1'b1;
               mem_nwr_d = 1'b1;
               state_d   = S_RELEASE;
               if (owner_d_q) begin
                  d_ack_d = 1'b1;
                  if (state_q == S_RD) begin
                     d_rdata_d = mem_rdata;
                  end
               end else begin
                  i_ack_d = 1'b1;
                  if (state_q == S_RD) begin
                     i_rdata_d = mem_rdata;
                  end
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               // Abort: release the strobe and ack without touching rdata.
               mem_nrd_d = 1'b1;
               mem_nwr_d = 1'b1;
               err_d     = 1'b1;
               state_d   = S_RELEASE;
               if (owner_d_q) begin
                  d_ack_d = 1'b1;
               end else begin
                  i_ack_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_RELEASE: begin
            // One strobe-high cycle lets the RAM's own counter return to 0.
            cnt_d     = '0;
            mem_nrd_d = 1'b1;
            mem_nwr_d = 1'b1;
            state_d   = S_IDLE;
         end

         default: begin
            cnt_d     = '0;
            mem_nrd_d = 1'b1;
            mem_nwr_d = 1'b1;
            state_d   = S_QUIET;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_QUIET;
         cnt_q       <= '0;
         prio_d_q    <= 1'b1;
         owner_d_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_nrd_q   <= 1'b1;
         mem_nwr_q   <= 1'b1;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prio_d_q    <= prio_d_d;
         owner_d_q   <= owner_d_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_nrd_q   <= mem_nrd_d;
         mem_nwr_q   <= mem_nwr_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_nRD   = mem_nrd_q;
   assign mem_nWR   = mem_nwr_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed bench for mem_port_arbiter with a 10-negedge byte-wide big-endian RAM model.
// Latency : RAM raises its status on the 10th negedge of a strobe, for one negedge-to-negedge period.
// Backpress: requesters hold req until their own ack, then drop or re-request.

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_nRD;
   logic        mem_nWR;
   logic [31:0] mem_rdata;
   logic        mem_readStatus;
   logic        mem_writeStatus;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .i_req           (i_req),
      .i_addr          (i_addr),
      .i_ack           (i_ack),
      .i_rdata         (i_rdata),
      .d_req           (d_req),
      .d_we            (d_we),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_ack           (d_ack),
      .d_rdata         (d_rdata),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_nRD         (mem_nRD),
      .mem_nWR         (mem_nWR),
      .mem_rdata       (mem_rdata),
      .mem_readStatus  (mem_readStatus),
      .mem_writeStatus (mem_writeStatus),
      .busy            (busy),
      .err             (err)
   );

   always #5 clk = ~clk;

   // ---------------- RAM model ----------------
   logic [7:0] ram [0:63];
   bit         ram_load = 1'b0;
   bit         ram_dead = 1'b0;
   int         ram_cnt  = 0;
   wire  [5:0] ram_a    = mem_addr[5:0];

   always @(negedge clk) begin
      if (ram_load) begin
         for (int k = 0; k < 64; k++) ram[k] <= 8'(k) ^ 8'hA5;
      end
      if (!mem_nRD || !mem_nWR) begin
         ram_cnt <= ram_cnt + 1;
         if (ram_cnt == 9 && !ram_dead) begin
            mem_readStatus  <= !mem_nRD;
            mem_writeStatus <= !mem_nWR;
            if (!mem_nRD) begin
               mem_rdata <= {ram[ram_a], ram[ram_a + 6'd1], ram[ram_a + 6'd2], ram[ram_a + 6'd3]};
            end else begin
               ram[ram_a]        <= mem_wdata[31:24];
               ram[ram_a + 6'd1] <= mem_wdata[23:16];
               ram[ram_a + 6'd2] <= mem_wdata[15:8];
               ram[ram_a + 6'd3] <= mem_wdata[7:0];
            end
         end else begin
            mem_readStatus  <= 1'b0;
            mem_writeStatus <= 1'b0;
         end
      end else begin
         ram_cnt         <= 0;
         mem_readStatus  <= 1'b0;
         mem_writeStatus <= 1'b0;
      end
   end

   // ---------------- bus monitor ----------------
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wire  strobe_low = !mem_nRD || !mem_nWR;
   logic prev_low   = 1'b0;
   logic [31:0] prev_addr  = '0;
   logic [31:0] prev_wdata = '0;
   int   grant_cyc[$];
   logic [31:0] grant_addr[$];
   bit   grant_wr[$];
   int   i_ack_cyc[$];
   int   d_ack_cyc[$];
   int   nrd_runs[$];
   int   nrd_run   = 0;
   int   i_ack_n   = 0;
   int   d_ack_n   = 0;
   int   overlap_n = 0;
   int   hold_n    = 0;

   always @(negedge clk) begin
      if (strobe_low && !prev_low) begin
         grant_cyc.push_back(cyc);
         grant_addr.push_back(mem_addr);
         grant_wr.push_back(!mem_nWR);
      end
      if (strobe_low && prev_low && (mem_addr != prev_addr || mem_wdata != prev_wdata))
         hold_n <= hold_n + 1;
      if (!mem_nRD && !mem_nWR) overlap_n <= overlap_n + 1;
      if (i_ack) begin
         i_ack_n <= i_ack_n + 1;
         i_ack_cyc.push_back(cyc);
      end
      if (d_ack) begin
         d_ack_n <= d_ack_n + 1;
         d_ack_cyc.push_back(cyc);
      end
      if (mem_nRD) begin
         nrd_run <= nrd_run + 1;
      end else if (nrd_run > 0) begin
         nrd_runs.push_back(nrd_run);
         nrd_run <= 0;
      end
      prev_low   <= strobe_low;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for_ack(input int limit, output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         tick();
         if (i_ack || d_ack) begin
            n = k;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; ram_load = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      tick(); tick();
      ram_load = 1'b0;
      tick();
      checks++; if (mem_nRD !== 1'b1) begin errors++; $display("FAIL reset_nRD: got %b want 1", mem_nRD); end
      checks++; if (mem_nWR !== 1'b1) begin errors++; $display("FAIL reset_nWR: got %b want 1", mem_nWR); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      checks++; if ({i_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {i_ack, d_ack}); end
      checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
   endtask

   task automatic test_store();
      int bad;
      int n;
      int d0;
      d0 = d_ack_n;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
      reset = 1'b0;
      bad = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (!mem_nRD || !mem_nWR) bad++;
         if (i == 11) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL quiet_busy11: got %b want 1", busy); end
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL quiet_strobe: %0d strobe cycles want 0", bad); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL quiet_len: busy %b after 12 cycles want 0", busy); end
      tick();
      checks++; if (mem_nWR !== 1'b0 || mem_nRD !== 1'b1) begin errors++; $display("FAIL store_strobe: nWR=%b nRD=%b want 0/1", mem_nWR, mem_nRD); end
      checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL store_addr: got %h want 8", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h want deadbeef", mem_wdata); end
      bad = 0; n = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (d_ack) begin
            n = k;
            break;
         end
         if (mem_nWR !== 1'b0) bad++;
      end
      checks++; if (n != 10) begin errors++; $display("FAIL store_latency: ack %0d cycles after grant want 10", n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL store_nwr_hold: %0d early releases want 0", bad); end
      checks++; if (mem_nWR !== 1'b1) begin errors++; $display("FAIL store_release: nWR %b at ack want 1", mem_nWR); end
      d_req = 1'b0; d_we = 1'b0;
      tick();
      checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL store_ack_width: d_ack %b want 0", d_ack); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", err); end
      checks++; if ({ram[8], ram[9], ram[10], ram[11]} !== 32'hDEADBEEF) begin errors++; $display("FAIL store_ram: got %h want deadbeef", {ram[8], ram[9], ram[10], ram[11]}); end
      checks++; if (d_ack_n - d0 != 1) begin errors++; $display("FAIL store_ack_count: %0d pulses want 1", d_ack_n - d0); end
   endtask

   task automatic test_load();
      int n;
      int i0;
      int g0;
      i0 = i_ack_n; g0 = grant_cyc.size();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      wait_for_ack(30, n);
      d_req = 1'b0;
      checks++; if (n != 11) begin errors++; $display("FAIL load_req_to_ack: %0d cycles want 11", n); end
      checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL load_ack: d_ack %b want 1", d_ack); end
      checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", d_rdata); end
      tick();
      checks++; if (d_ack_cyc[$] - grant_cyc[g0] != 10) begin errors++; $display("FAIL load_latency: %0d want 10", d_ack_cyc[$] - grant_cyc[g0]); end
      checks++; if (grant_wr[g0] !== 1'b0) begin errors++; $display("FAIL load_kind: write strobe %b want 0", grant_wr[g0]); end
      checks++; if (i_ack_n != i0) begin errors++; $display("FAIL load_i_ack: %0d i_ack pulses want 0", i_ack_n - i0); end
   endtask

   task automatic test_fetch3();
      int seen;
      int ia;
      int rb;
      int d0;
      ia = i_ack_cyc.size(); rb = nrd_runs.size(); d0 = d_ack_n;
      seen = 0;
      i_req = 1'b1; i_addr = 32'h10;
      for (int k = 0; k < 60 && seen < 3; k++) begin
         tick();
         if (i_ack) seen++;
      end
      i_req = 1'b0;
      tick();
      checks++; if (seen != 3) begin errors++; $display("FAIL fetch3_acks: %0d seen want 3", seen); end
      checks++; if (i_ack_cyc.size() - ia != 3) begin errors++; $display("FAIL fetch3_width: %0d ack cycles want 3", i_ack_cyc.size() - ia); end
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (i_ack_cyc[ia + k] - i_ack_cyc[ia + k - 1] != 12) begin
            errors++; $display("FAIL fetch3_spacing%0d: %0d want 12", k, i_ack_cyc[ia + k] - i_ack_cyc[ia + k - 1]);
         end
         checks++;
         if (nrd_runs[rb + k] != 2) begin
            errors++; $display("FAIL fetch3_gap%0d: nRD high %0d cycles want 2", k, nrd_runs[rb + k]);
         end
      end
      checks++; if (i_rdata !== 32'hB5B4B7B6) begin errors++; $display("FAIL fetch3_data: got %h want b5b4b7b6", i_rdata); end
      checks++; if (d_ack_n != d0) begin errors++; $display("FAIL fetch3_d_ack: %0d pulses want 0", d_ack_n - d0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr [4];
      int dn;
      int in_n;
      int gb;
      int i0;
      int d0;
      int ov0;
      int h0;
      exp_addr[0] = 32'h04; exp_addr[1] = 32'h30; exp_addr[2] = 32'h04; exp_addr[3] = 32'h30;
      gb = grant_cyc.size(); i0 = i_ack_n; d0 = d_ack_n; ov0 = overlap_n; h0 = hold_n;
      dn = 0; in_n = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h04;
      i_req = 1'b1; i_addr = 32'h30;
      for (int k = 0; k < 80 && (dn + in_n) < 4; k++) begin
         tick();
         if (d_ack) begin
            dn++;
            if (dn == 2) d_req = 1'b0;
         end
         if (i_ack) begin
            in_n++;
            if (in_n == 2) i_req = 1'b0;
         end
      end
      d_req = 1'b0; i_req = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (grant_addr[gb + k] !== exp_addr[k]) begin
            errors++; $display("FAIL b2b_order%0d: addr %h want %h", k, grant_addr[gb + k], exp_addr[k]);
         end
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (grant_cyc[gb + k] - grant_cyc[gb + k - 1] != 12) begin
            errors++; $display("FAIL b2b_period%0d: %0d want 12", k, grant_cyc[gb + k] - grant_cyc[gb + k - 1]);
         end
      end
      checks++; if (d_ack_n - d0 != 2 || i_ack_n - i0 != 2) begin errors++; $display("FAIL b2b_ack_cycles: d=%0d i=%0d want 2/2", d_ack_n - d0, i_ack_n - i0); end
      checks++; if (overlap_n != ov0) begin errors++; $display("FAIL b2b_overlap: %0d cycles want 0", overlap_n - ov0); end
      checks++; if (hold_n != h0) begin errors++; $display("FAIL b2b_hold: %0d changes want 0", hold_n - h0); end
      checks++; if (d_rdata !== 32'hA1A0A3A2) begin errors++; $display("FAIL b2b_d_data: got %h want a1a0a3a2", d_rdata); end
      checks++; if (i_rdata !== 32'h95949796) begin errors++; $display("FAIL b2b_i_data: got %h want 95949796", i_rdata); end
   endtask

   task automatic test_timeout();
      int n;
      int g0;
      g0 = grant_cyc.size();
      ram_dead = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0C;
      wait_for_ack(40, n);
      d_req = 1'b0;
      checks++; if (n < 0 || d_ack !== 1'b1) begin errors++; $display("FAIL tmo_ack: n=%0d d_ack=%b want ack", n, d_ack); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", err); end
      checks++; if (mem_nRD !== 1'b1) begin errors++; $display("FAIL tmo_release: nRD %b want 1", mem_nRD); end
      checks++; if (d_rdata !== 32'hA1A0A3A2) begin errors++; $display("FAIL tmo_rdata: got %h want a1a0a3a2 (unchanged)", d_rdata); end
      tick();
      checks++; if (d_ack_cyc[$] - grant_cyc[g0] != 15) begin errors++; $display("FAIL tmo_latency: %0d want 15", d_ack_cyc[$] - grant_cyc[g0]); end
      tick(); tick();
      ram_dead = 1'b0;
      i_req = 1'b1; i_addr = 32'h20;
      wait_for_ack(30, n);
      i_req = 1'b0;
      checks++; if (n < 0 || i_ack !== 1'b1) begin errors++; $display("FAIL tmo_next_ack: n=%0d i_ack=%b want ack", n, i_ack); end
      checks++; if (i_rdata !== 32'h85848786) begin errors++; $display("FAIL tmo_next_data: got %h want 85848786", i_rdata); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: err %b want 1", err); end
      tick();
      checks++; if (i_ack_cyc[$] - grant_cyc[g0 + 1] != 10) begin errors++; $display("FAIL tmo_next_latency: %0d want 10", i_ack_cyc[$] - grant_cyc[g0 + 1]); end
   endtask

   task automatic test_reset_mid_access();
      int found;
      int bad;
      int n;
      int i0;
      i0 = i_ack_n;
      found = 0;
      i_req = 1'b1; i_addr = 32'h04;
      for (int k = 0; k < 20 && found == 0; k++) begin
         tick();
         if (!mem_nRD) found = 1;
      end
      checks++; if (found != 1) begin errors++; $display("FAIL rst_mid_grant: no read strobe seen"); end
      for (int k = 0; k < 5; k++) tick();
      #2 reset = 1'b1;
      #1;
      checks++; if (mem_nRD !== 1'b1) begin errors++; $display("FAIL rst_mid_strobe: nRD %b want 1", mem_nRD); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", err); end
      checks++; if (busy !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_regs: busy=%b addr=%h want 1/0", busy, mem_addr); end
      checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", i_rdata); end
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (!mem_nRD || !mem_nWR || i_ack) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: %0d active cycles want 0", bad); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet_len: busy %b want 0", busy); end
      wait_for_ack(30, n);
      i_req = 1'b0;
      checks++; if (n != 11 || i_ack !== 1'b1) begin errors++; $display("FAIL rst_mid_regrant: ack after %0d cycles want 11", n); end
      checks++; if (i_rdata !== 32'hA1A0A3A2) begin errors++; $display("FAIL rst_mid_data: got %h want a1a0a3a2", i_rdata); end
      tick();
      checks++; if (i_ack_n - i0 != 1) begin errors++; $display("FAIL rst_mid_ack_count: %0d pulses want 1", i_ack_n - i0); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_fetch3();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
